skinny_sub_cells_ctrl: RTL
==========================

SKINNY_SUB_CELLS_CTRL -- requirements
Module: skinny_sub_cells_ctrl

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 3, meaning downstream two-sbox pipeline latency in cycles.
REQ-002 SHALL have parameter SEED_RST, default 64'hA5A5_5A5A_0F0F_F0F0, meaning PRNG reset value; used only with REQ-024 macro.
REQ-003 SHALL have port clk  in  1  single clock, all flops rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports start  in  1  request one SubCells pass; busy  out  1  pass in progress; done  out  1  one-cycle pulse, result valid.
REQ-006 SHALL have ports state1/state2/state3  in  64 each  three shares of the 16-nibble state.
REQ-007 SHALL have ports res1/res2/res3  out  64 each  three shares of the substituted state.
REQ-008 SHALL have ports sbox_in1/2/3  out  8 each  byte shares to the two-sbox stage; sbox_r  out  64  fresh randomness to that stage.
REQ-009 SHALL have ports sbox_out1/2/3  in  8 each  byte shares returned by the two-sbox stage.

Function
REQ-010 SHALL use FSM states IDLE, FEED, DRAIN, FIN; IDLE->FEED on start; FEED->DRAIN after byte 7 issued; DRAIN->FIN when byte 7 captured; FIN->IDLE unconditionally.
REQ-011 SHALL register all three input shares in the cycle start is sampled high in IDLE (cycle 0).
REQ-012 SHALL present byte k (bits [8k+7:8k] of each share), k=0..7, on sbox_in1/2/3 in cycle 1+k, via a 3-bit issue counter.
REQ-013 SHALL drive sbox_in1/2/3 to zero whenever not in FEED.
REQ-014 SHALL track in-flight bytes with a SBOX_LAT-deep valid shift register and capture sbox_out1/2/3 into byte k of res1/2/3 at the end of cycle 1+k+SBOX_LAT, via a 3-bit capture counter.
REQ-015 SHALL assert done for exactly cycle 9+SBOX_LAT (cycle 12 at default) and busy from cycle 1 through that cycle inclusive.
REQ-016 SHALL ignore start while busy; start in the FIN cycle is also ignored.
REQ-017 SHALL hold res1/2/3 stable from done until the next accepted pass overwrites byte 0.
REQ-018 SHALL supply a distinct 64-bit sbox_r value in every FEED cycle; sbox_r SHALL be zero outside FEED.
REQ-019 SHALL never combine shares of the same byte in any logic; each share path stays separate.

Reset
REQ-020 SHALL on rst_i low immediately force state IDLE, busy=0, done=0, res1/2/3=0, counters=0, valid shift register=0, sbox_in and sbox_r=0.
REQ-021 SHALL abandon a pass interrupted by reset; bytes still in flight after reset release SHALL NOT be captured.
REQ-022 SHALL accept start in the first cycle after rst_i deasserts.

Configuration
REQ-023 Without SKINNY_INT_PRNG_EN: input port rnd_i (64 bits) SHALL pass through to sbox_r during FEED; the bench supplies fresh values.
REQ-024 With SKINNY_INT_PRNG_EN: rnd_i removed, input seed_i (64 bits) added; a 64-bit Fibonacci LFSR (taps 63,62,60,59, shift left, new bit into bit 0) resets to SEED_RST, loads seed_i on accepted start when seed_i != 0, advances once per FEED cycle, and drives sbox_r.

Structure
REQ-025 SHALL place FSM state enum, NUM_BYTES=8, LFSR tap constants and default seed in shared package skinny_ctrl_pkg.
REQ-026 SHALL implement the LFSR as sub-module skinny_prng64, instantiated only with SKINNY_INT_PRNG_EN.
REQ-027 SHALL NOT instantiate the two-sbox stage; the bench or top level connects it.

Verification
REQ-028 Shares state1=0, state2=0, state3=0, start pulse, behavioural masked sbox of latency 3 -> done in cycle 12; res1^res2^res3=64'hCCCC_CCCC_CCCC_CCCC.
REQ-029 Unshared 64'h0123456789ABCDEF split with random masks -> XOR of results 64'hC6901A2B385D4E7F; each share individually differs from it.
REQ-030 start held high continuously -> passes accepted every 13 cycles (12 busy/done + 1 IDLE), start ignored while busy; done pulses exactly once per pass.
REQ-031 rst_i low in cycle 6 of a pass -> all outputs zero immediately; after release, new pass with REQ-029 data yields correct result without corruption from stale bytes.
REQ-032 With SKINNY_INT_PRNG_EN, seed_i=64'h1 -> eight sbox_r values match LFSR reference model and are pairwise distinct; seed_i=0 -> LFSR continues from previous value.
REQ-033 SBOX_LAT=5 -> done in cycle 14; result unchanged from REQ-029.

Source files
------------

// File: rtl/skinny_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// skinny_ctrl_pkg
// Shared definitions for the SKINNY SubCells controller. It holds:
//   - the controller FSM state type,
//   - the number of state bytes handled per pass,
//   - the tap mask and default seed of the 64-bit Fibonacci LFSR,
//   - a one-step LFSR update function.
// The LFSR is used only when SKINNY_INT_PRNG_EN is defined.
// ---------------------------------------------------------------------------
package skinny_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } ctrl_state_e;

    localparam int          NUM_BYTES    = 8;
    // Feedback taps are bits 63, 62, 60 and 59.
    localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED = 64'hA5A5_5A5A_0F0F_F0F0;

    // Shift left by one and place the XOR of the tapped bits in bit 0.
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/skinny_prng64.sv
// ---------------------------------------------------------------------------
// skinny_prng64
// 64-bit Fibonacci LFSR that supplies fresh randomness to the masked
// two-sbox stage. It is instantiated by the top only when
// SKINNY_INT_PRNG_EN is defined.
// Ports:
//   clk     in   1   rising-edge clock
//   rst_i   in   1   asynchronous active-low reset; loads SEED_RST
//   i_load  in   1   load i_seed. This takes priority over i_adv.
//   i_seed  in  64   value loaded on i_load
//   i_adv   in   1   advance the register by one step
//   o_state out 64   current LFSR contents
// ---------------------------------------------------------------------------
module skinny_prng64
    import skinny_ctrl_pkg::*;
#(
    parameter logic [63:0] SEED_RST = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        i_load,
    input  logic [63:0] i_seed,
    input  logic        i_adv,
    output logic [63:0] o_state
);

    logic [63:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= SEED_RST;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_adv) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/skinny_sub_cells_ctrl.sv
// ---------------------------------------------------------------------------
// skinny_sub_cells_ctrl
// Sequences one masked SubCells pass over a three-share, 16-nibble state.
// - It sends one byte (two nibbles) per cycle to an external masked
//   two-sbox stage whose latency is SBOX_LAT.
// - It collects the returned byte shares into res1/2/3.
// - The three share paths are never combined.
// Ports:
//   clk, rst_i                   clock and asynchronous active-low reset
//   start / busy / done          pass request, pass in progress, result-valid pulse
//   state1..3     in  64         input shares
//   res1..3       out 64         substituted output shares
//   sbox_in1..3   out  8         byte shares to the two-sbox stage; zero outside FEED
//   sbox_r        out 64         fresh randomness to the stage; zero outside FEED
//   sbox_out1..3  in   8         byte shares returned by the stage
//   rnd_i         in  64         external randomness (default build)
//   seed_i        in  64         LFSR seed (only with SKINNY_INT_PRNG_EN)
// Build option:
//   When the macro SKINNY_INT_PRNG_EN is defined, an internal LFSR generates
//   the randomness. In that build, rnd_i is replaced by seed_i.
// ---------------------------------------------------------------------------
module skinny_sub_cells_ctrl
    import skinny_ctrl_pkg::*;
#(
    parameter int          SBOX_LAT = 3,
    parameter logic [63:0] SEED_RST = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [63:0] state1,
    input  logic [63:0] state2,
    input  logic [63:0] state3,
    output logic [63:0] res1,
    output logic [63:0] res2,
    output logic [63:0] res3,
    output logic [7:0]  sbox_in1,
    output logic [7:0]  sbox_in2,
    output logic [7:0]  sbox_in3,
    output logic [63:0] sbox_r,
    input  logic [7:0]  sbox_out1,
    input  logic [7:0]  sbox_out2,
    input  logic [7:0]  sbox_out3,
`ifdef SKINNY_INT_PRNG_EN
    input  logic [63:0] seed_i
`else
    input  logic [63:0] rnd_i
`endif
);

    ctrl_state_e         r_state, w_next;
    logic [63:0]         r_sh1, r_sh2, r_sh3;
    logic [63:0]         r_res1, r_res2, r_res3;
    logic [2:0]          r_issue, r_cap;
    logic [SBOX_LAT-1:0] r_vld;
    logic                w_accept, w_feed, w_cap, w_last_cap;
    logic [63:0]         w_rnd;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_feed     = (r_state == FEED);
    // The oldest valid bit marks a returned byte that can be captured this cycle.
    assign w_cap      = r_vld[SBOX_LAT-1];
    assign w_last_cap = w_cap && (r_cap == 3'(NUM_BYTES - 1));

    always_comb begin
        w_next   = r_state;
        busy     = (r_state != IDLE);
        done     = 1'b0;
        sbox_in1 = '0;
        sbox_in2 = '0;
        sbox_in3 = '0;
        case (r_state)
            IDLE:  if (start) w_next = FEED;
            FEED: begin
                sbox_in1 = r_sh1[{r_issue, 3'b000} +: 8];
                sbox_in2 = r_sh2[{r_issue, 3'b000} +: 8];
                sbox_in3 = r_sh3[{r_issue, 3'b000} +: 8];
                if (r_issue == 3'(NUM_BYTES - 1)) w_next = DRAIN;
            end
            DRAIN: if (w_last_cap) w_next = FIN;
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_sh3   <= '0;
            r_res1  <= '0;
            r_res2  <= '0;
            r_res3  <= '0;
            r_issue <= '0;
            r_cap   <= '0;
            r_vld   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sh1 <= state1;
                r_sh2 <= state2;
                r_sh3 <= state3;
            end
            // Both counters wrap to 0 after byte 7, so they are ready for the next pass.
            if (w_feed) begin
                r_issue <= r_issue + 3'd1;
            end
            r_vld[0] <= w_feed;
            for (int i = 1; i < SBOX_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_cap) begin
                r_res1[{r_cap, 3'b000} +: 8] <= sbox_out1;
                r_res2[{r_cap, 3'b000} +: 8] <= sbox_out2;
                r_res3[{r_cap, 3'b000} +: 8] <= sbox_out3;
                r_cap <= r_cap + 3'd1;
            end
        end
    end

`ifdef SKINNY_INT_PRNG_EN
    skinny_prng64 #(
        .SEED_RST (SEED_RST)
    ) u_prng (
        .clk     (clk),
        .rst_i   (rst_i),
        .i_load  (w_accept && (seed_i != '0)),
        .i_seed  (seed_i),
        .i_adv   (w_feed),
        .o_state (w_rnd)
    );
`else
    // In this build the seed parameter has no consumer.
    logic w_unused_seed;
    assign w_unused_seed = ^SEED_RST;
    assign w_rnd         = rnd_i;
`endif

    assign sbox_r = w_feed ? w_rnd : '0;
    assign res1   = r_res1;
    assign res2   = r_res2;
    assign res3   = r_res3;

endmodule
